// File: rtl/spi_master_param.sv
// SPI master: runtime cpol/cpha/bit order, parameterised width, selects, divider.
// Transfer runs SETUP, 2*DATA_W sclk half-periods, then HOLD before done.
module spi_master_param #(
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 4,
   parameter int HALF_DIV   = 2,
   localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic [DATA_W-1:0]     tx_data,
   input  logic                  miso,
   output logic                  sclk,
   output logic                  mosi,
   output logic [NUM_SLAVES-1:0] ss_n,
   output logic [DATA_W-1:0]     rx_data,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int TOG_W = $clog2(2 * DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);
   localparam logic [TOG_W-1:0] TOG_MAX = TOG_W'(2 * DATA_W);
   localparam logic [SEL_W:0]   SEL_LIM = (SEL_W + 1)'(NUM_SLAVES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_XFER,
      S_HOLD
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TOG_W-1:0]        tog_q, tog_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;
   logic [NUM_SLAVES-1:0]   ss_n_q, ss_n_d;
   logic [DATA_W-1:0]       tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0]       rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0]       rx_data_q, rx_data_d;
   logic                    done_q, done_d;
   logic                    cpol_q, cpol_d;
   logic                    cpha_q, cpha_d;
   logic                    lsb_q, lsb_d;

   logic                    accept;
   logic                    half_end;
   logic                    step;
   logic                    lead;
   logic [DATA_W-1:0]       word;

   function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
      return r;
   endfunction

   assign accept   = (state_q == S_IDLE) && start &&
                     ({1'b0, slave_sel} < SEL_LIM);
   assign half_end = (cnt_q == CNT_MAX);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tog_d     = tog_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ss_n_d    = ss_n_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      step      = 1'b0;
      lead      = 1'b0;
      // Shifter always emits its MSB; LSB-first words are reversed on entry.
      word      = lsb_first ? rev(tx_data) : tx_data;

      unique case (state_q)
         S_IDLE: begin
            sclk_d = cpol;
            if (accept) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               tog_d   = '0;
               cpol_d  = cpol;
               cpha_d  = cpha;
               lsb_d   = lsb_first;
               ss_n_d  = ~(NUM_SLAVES'(1) << slave_sel);
               rx_sh_d = '0;
               if (!cpha) begin
                  mosi_d  = word[DATA_W-1];
                  tx_sh_d = word << 1;
               end else begin
                  tx_sh_d = word;
               end
            end
         end
         S_SETUP: begin
            cnt_d = cnt_q + 1'b1;
            if (half_end) begin
               cnt_d   = '0;
               state_d = S_XFER;
               step    = 1'b1;
            end
         end
         S_XFER: begin
            cnt_d = cnt_q + 1'b1;
            if (half_end) begin
               cnt_d = '0;
               if (tog_q == TOG_MAX) state_d = S_HOLD;
               else step = 1'b1;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (half_end) begin
               cnt_d     = '0;
               state_d   = S_IDLE;
               ss_n_d    = '1;
               done_d    = 1'b1;
               mosi_d    = 1'b0;
               rx_data_d = lsb_q ? rev(rx_sh_q) : rx_sh_q;
            end
         end
      endcase

      if (step) begin
         sclk_d = ~sclk_q;
         tog_d  = tog_q + 1'b1;
         lead   = ~tog_q[0];
         if (lead == cpha_q) begin
            // Trailing-edge launch skips the final edge: no bit is left.
            if (cpha_q || (tog_q != TOG_MAX - 1'b1)) begin
               mosi_d  = tx_sh_q[DATA_W-1];
               tx_sh_d = tx_sh_q << 1;
            end
         end else begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tog_q     <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         ss_n_q    <= '1;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         done_q    <= 1'b0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tog_q     <= tog_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ss_n_q    <= ss_n_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         lsb_q     <= lsb_d;
      end
   end

   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign ss_n    = ss_n_q;
   assign rx_data = rx_data_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an SPI slave model watches sclk edges,
// records mosi and serves miso; tests compare against spec-derived values.
module tb_spi_master_param;

   localparam int DW  = 8;
   localparam int LAT = (2 * DW + 2) * 2;

   logic       clk = 0, rst = 0, start = 0, start3 = 0;
   logic       cpol = 0, cpha = 0, lsb_first = 0;
   logic [1:0] slave_sel = 0, sel3 = 0;
   logic [7:0] tx_data = 0;
   logic       miso;
   logic       sclk, mosi, busy, done;
   logic [3:0] ss_n;
   logic [7:0] rx_data;
   logic       sclk3, mosi3, busy3, done3;
   logic [2:0] ss_n3;
   logic [7:0] rx3;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;

   bit         loop_mode = 0;
   logic       slv_miso = 0;
   logic [7:0] s_word = 0;
   logic       s_cpol = 0, s_cpha = 0, s_lsb = 0;
   logic [3:0] exp_ss = 4'hF;
   int         s_idx, busy_rise, edges, lead_cnt, ss_bad, done_cnt, lat;
   int         rx_bad = 0;
   int         done_cycs[$];
   logic [7:0] mosi_word;
   logic [7:0] prev_rx = 0;
   logic       prev_busy = 0, prev_sclk = 0, is_lead;

   assign miso = loop_mode ? mosi : slv_miso;

   spi_master_param #(.DATA_W(8), .NUM_SLAVES(4), .HALF_DIV(2)) dut (
      .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .tx_data(tx_data),
      .miso(miso), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
      .rx_data(rx_data), .busy(busy), .done(done)
   );

   spi_master_param #(.DATA_W(8), .NUM_SLAVES(3), .HALF_DIV(2)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .slave_sel(sel3),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .tx_data(tx_data),
      .miso(miso), .sclk(sclk3), .mosi(mosi3), .ss_n(ss_n3),
      .rx_data(rx3), .busy(busy3), .done(done3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic logic sbit(input int i);
      if (i > DW - 1) return 1'b0;
      return s_lsb ? s_word[i] : s_word[DW-1-i];
   endfunction

   function automatic logic [7:0] order(input logic [7:0] w, input logic lsb);
      logic [7:0] r;
      for (int i = 0; i < DW; i++) r[DW-1-i] = lsb ? w[i] : w[DW-1-i];
      return r;
   endfunction

   // Slave model: samples mosi on its sample edge, shifts miso on the other.
   always @(negedge clk) begin
      if (!rst) begin
         prev_busy = 0;
         prev_sclk = sclk;
         prev_rx   = rx_data;
      end else begin
         if (busy && !prev_busy) begin
            busy_rise = cyc;
            edges = 0; lead_cnt = 0; ss_bad = 0; mosi_word = '0;
            s_idx = s_cpha ? 0 : 1;
            if (!s_cpha) slv_miso = sbit(0);
         end
         if (busy && ss_n !== exp_ss) ss_bad++;
         if (busy && sclk !== prev_sclk) begin
            edges++;
            is_lead = (sclk !== s_cpol);
            if (is_lead) lead_cnt++;
            if (is_lead != s_cpha) mosi_word = {mosi_word[DW-2:0], mosi};
            else begin slv_miso = sbit(s_idx); s_idx++; end
         end
         if (done) begin
            done_cnt++;
            lat = cyc - busy_rise;
            done_cycs.push_back(cyc);
         end
         if (rx_data !== prev_rx && !done) rx_bad++;
         prev_busy = busy;
         prev_sclk = sclk;
         prev_rx   = rx_data;
      end
   end

   task automatic cfg(input logic [7:0] tx, input int sel, input logic pol,
                      input logic pha, input logic lsb, input logic [7:0] sw,
                      input bit lp);
      @(negedge clk);
      tx_data = tx; slave_sel = 2'(sel);
      cpol = pol; cpha = pha; lsb_first = lsb;
      s_word = sw; s_cpol = pol; s_cpha = pha; s_lsb = lsb; loop_mode = lp;
      exp_ss = ~(4'b1 << sel);
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_start();
      done_cnt = 0;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(output bit to);
      to = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin to = 0; break; end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 0;
      start = 1;
      repeat (3) @(negedge clk);
      n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk got %b exp 0", sclk); end
      n_chk++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi got %b exp 0", mosi); end
      n_chk++; if (ss_n !== 4'hF) begin n_fail++; $display("FAIL rst_ss_n got %b exp 1111", ss_n); end
      n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx got %h exp 00", rx_data); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
      n_chk++; if (ss_n3 !== 3'b111) begin n_fail++; $display("FAIL rst_ss_n3 got %b exp 111", ss_n3); end
      start = 0;
      rst = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_idle_cpol();
      @(negedge clk);
      cpol = 1;
      #1;
      n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL idle_cpol_nodelay got %b exp 0", sclk); end
      @(negedge clk);
      n_chk++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL idle_cpol_rise got %b exp 1", sclk); end
      cpol = 0;
      @(negedge clk);
      n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL idle_cpol_fall got %b exp 0", sclk); end
   endtask

   task automatic test_mode0_loop();
      bit to;
      cfg(8'hA5, 2, 0, 0, 0, 8'h00, 1);
      pulse_start();
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL m0_busy got %b exp 1", busy); end
      n_chk++; if (ss_n !== 4'b1011) begin n_fail++; $display("FAIL m0_ss_n got %b exp 1011", ss_n); end
      n_chk++; if (mosi !== 1'b1) begin n_fail++; $display("FAIL m0_setup_mosi got %b exp 1", mosi); end
      wait_done(to);
      n_chk++; if (to) begin n_fail++; $display("FAIL m0_timeout got none exp done"); end
      n_chk++; if (mosi_word !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi got %h exp a5", mosi_word); end
      n_chk++; if (edges !== 16) begin n_fail++; $display("FAIL m0_edges got %0d exp 16", edges); end
      n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL m0_latency got %0d exp %0d", lat, LAT); end
      n_chk++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL m0_rx got %h exp a5", rx_data); end
      n_chk++; if (ss_bad !== 0) begin n_fail++; $display("FAIL m0_ss_hold got %0d bad exp 0", ss_bad); end
      n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL m0_done_cnt got %0d exp 1", done_cnt); end
      n_chk++; if (ss_n !== 4'hF || mosi !== 1'b0) begin n_fail++; $display("FAIL m0_after got ss %b mosi %b exp 1111 0", ss_n, mosi); end
   endtask

   task automatic test_mode3_lsb();
      bit to;
      cfg(8'h3C, 1, 1, 1, 1, 8'h96, 0);
      n_chk++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk got %b exp 1", sclk); end
      pulse_start();
      wait_done(to);
      n_chk++; if (to) begin n_fail++; $display("FAIL m3_timeout got none exp done"); end
      n_chk++; if (mosi_word !== 8'b0011_1100) begin n_fail++; $display("FAIL m3_mosi got %b exp 00111100", mosi_word); end
      n_chk++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL m3_rx got %h exp 96", rx_data); end
      n_chk++; if (edges !== 16) begin n_fail++; $display("FAIL m3_edges got %0d exp 16", edges); end
      n_chk++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_end_sclk got %b exp 1", sclk); end
   endtask

   task automatic test_ignore_busy();
      bit to;
      cfg(8'h11, 0, 0, 0, 0, 8'h5A, 0);
      pulse_start();
      repeat (9) @(negedge clk);
      tx_data = 8'h22; slave_sel = 2'd3; lsb_first = 1; cpha = 1;
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done(to);
      repeat (40) @(negedge clk);
      n_chk++; if (to) begin n_fail++; $display("FAIL ign_timeout got none exp done"); end
      n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_cnt got %0d exp 1", done_cnt); end
      n_chk++; if (mosi_word !== 8'h11) begin n_fail++; $display("FAIL ign_mosi got %h exp 11", mosi_word); end
      n_chk++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL ign_rx got %h exp 5a", rx_data); end
      n_chk++; if (ss_bad !== 0) begin n_fail++; $display("FAIL ign_ss got %0d bad exp 0", ss_bad); end
      n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL ign_latency got %0d exp %0d", lat, LAT); end
   endtask

   task automatic test_back_to_back();
      bit seen;
      cfg(8'hC3, 3, 0, 1, 0, 8'h00, 1);
      done_cycs.delete();
      done_cnt = 0;
      start = 1;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      @(negedge clk);
      start = 0;
      n_chk++; if (!seen || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_rebusy got %b exp 1", busy); end
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      repeat (6) @(negedge clk);
      n_chk++; if (done_cycs.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", done_cycs.size()); end
      if (done_cycs.size() >= 2) begin
         n_chk++; if (done_cycs[1] - done_cycs[0] !== LAT + 1) begin n_fail++; $display("FAIL b2b_gap got %0d exp %0d", done_cycs[1] - done_cycs[0], LAT + 1); end
      end
      n_chk++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_rx got %h exp c3", rx_data); end
   endtask

   task automatic test_reset_mid();
      bit to;
      int leads, snap;
      logic last;
      cfg(8'hF0, 1, 0, 0, 0, 8'h0F, 0);
      pulse_start();
      leads = 0; last = sclk;
      for (int i = 0; i < 100 && leads < 4; i++) begin
         @(negedge clk);
         if (sclk && !last) leads++;
         last = sclk;
      end
      rst = 0;
      #1;
      n_chk++; if (ss_n !== 4'hF) begin n_fail++; $display("FAIL midrst_ss got %b exp 1111", ss_n); end
      n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk got %b exp 0", sclk); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
      n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx got %h exp 00", rx_data); end
      snap = done_cnt;
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (40) @(negedge clk);
      n_chk++; if (done_cnt !== snap) begin n_fail++; $display("FAIL midrst_done got %0d exp %0d", done_cnt, snap); end
      cfg(8'hF0, 1, 0, 0, 0, 8'h0F, 0);
      pulse_start();
      wait_done(to);
      n_chk++; if (to || lat !== LAT) begin n_fail++; $display("FAIL postrst_latency got %0d exp %0d", lat, LAT); end
      n_chk++; if (mosi_word !== 8'hF0) begin n_fail++; $display("FAIL postrst_mosi got %h exp f0", mosi_word); end
      n_chk++; if (rx_data !== 8'h0F) begin n_fail++; $display("FAIL postrst_rx got %h exp 0f", rx_data); end
   endtask

   task automatic test_num_slaves3();
      int bad, k;
      @(negedge clk);
      sel3 = 2'd3; start3 = 1;
      @(negedge clk);
      start3 = 0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy3 !== 1'b0 || ss_n3 !== 3'b111 || done3 !== 1'b0) bad++;
         @(negedge clk);
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL ns3_ignore got %0d bad cycles exp 0", bad); end
      sel3 = 2'd2; start3 = 1;
      @(negedge clk);
      start3 = 0;
      n_chk++; if (busy3 !== 1'b1 || ss_n3 !== 3'b011) begin n_fail++; $display("FAIL ns3_accept got busy %b ss %b exp 1 011", busy3, ss_n3); end
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         k++;
         if (done3) break;
      end
      n_chk++; if (k !== LAT) begin n_fail++; $display("FAIL ns3_latency got %0d exp %0d", k, LAT); end
   endtask

   task automatic test_random();
      bit to;
      logic [7:0] tx, sw, exp_rx;
      int sel;
      logic pol, pha, lsb;
      bit lp;
      for (int n = 0; n < 6; n++) begin
         tx = 8'($urandom); sw = 8'($urandom);
         sel = $urandom_range(0, 3);
         pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
         lp = 1'($urandom);
         exp_rx = lp ? tx : sw;
         cfg(tx, sel, pol, pha, lsb, sw, lp);
         pulse_start();
         wait_done(to);
         n_chk++; if (to || lat !== LAT) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, lat, LAT); end
         n_chk++; if (edges !== 16) begin n_fail++; $display("FAIL rnd%0d_edges got %0d exp 16", n, edges); end
         n_chk++; if (mosi_word !== order(tx, lsb)) begin n_fail++; $display("FAIL rnd%0d_mosi got %h exp %h", n, mosi_word, order(tx, lsb)); end
         n_chk++; if (rx_data !== exp_rx) begin n_fail++; $display("FAIL rnd%0d_rx got %h exp %h", n, rx_data, exp_rx); end
         n_chk++; if (ss_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_ss got %0d bad exp 0", n, ss_bad); end
         n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_done got %0d exp 1", n, done_cnt); end
         n_chk++; if (sclk !== pol) begin n_fail++; $display("FAIL rnd%0d_idle got %b exp %b", n, sclk, pol); end
      end
   endtask

   initial begin
      test_reset();
      test_idle_cpol();
      test_mode0_loop();
      test_mode3_lsb();
      test_ignore_busy();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_num_slaves3();
      n_chk++; if (rx_bad !== 0) begin n_fail++; $display("FAIL rx_hold got %0d changes exp 0", rx_bad); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, bits per transfer (>=2).
REQ-002 The block SHALL have parameter NUM_SLAVES, default 4, number of slave-select lines (>=1).
REQ-003 The block SHALL have parameter HALF_DIV, default 2, clk cycles per sclk half-period (>=1).
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  transfer request, sampled each clk.
REQ-007 slave_sel  in  max(1,clog2(NUM_SLAVES))  target slave index.
REQ-008 cpol  in  1  sclk idle level.
REQ-009 cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-010 lsb_first  in  1  bit order; 0 = MSB first.
REQ-011 tx_data  in  DATA_W  word to send.
REQ-012 miso  in  1  serial data from slave.
REQ-013 sclk  out  1  serial clock, registered.
REQ-014 mosi  out  1  serial data to slave, registered.
REQ-015 ss_n  out  NUM_SLAVES  slave selects, active-low, at most one low.
REQ-016 rx_data  out  DATA_W  last received word.
REQ-017 busy  out  1  high while a transfer is in progress.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, XFER and HOLD; busy=1 in every state except IDLE.
REQ-020 In IDLE, start=1 with slave_sel<NUM_SLAVES SHALL latch tx_data, slave_sel, cpol, cpha and lsb_first and enter SETUP next cycle; busy and ss_n[sel]=0 both SHALL assert in that same next cycle.
REQ-021 start with slave_sel>=NUM_SLAVES SHALL be ignored: the FSM stays in IDLE, no ss_n line asserts and done does not pulse.
REQ-022 start while busy=1 SHALL be ignored; input changes during a transfer SHALL NOT affect it.
REQ-023 SETUP SHALL last HALF_DIV cycles with sclk=latched cpol; when cpha=0, mosi SHALL present the first bit throughout SETUP.
REQ-024 XFER SHALL toggle sclk every HALF_DIV cycles, for exactly 2*DATA_W toggles; odd toggles are leading edges and even toggles are trailing edges.
REQ-025 cpha=0: miso SHALL be captured on the clk edge that produces each leading edge; mosi SHALL advance on each trailing edge except the last.
REQ-026 cpha=1: mosi SHALL advance on each leading edge (the first leading edge presents the first bit); miso SHALL be captured on the clk edge that produces each trailing edge.
REQ-027 Bit order SHALL be tx_data[DATA_W-1] down to [0] when lsb_first=0, and [0] up to [DATA_W-1] when lsb_first=1; received bits SHALL be assembled in the same order.
REQ-028 HOLD SHALL last HALF_DIV cycles with sclk=cpol and ss_n still asserted.
REQ-029 On leaving HOLD, in one cycle: ss_n SHALL go all-ones, busy=0, done=1, rx_data SHALL load the assembled word and mosi=0.
REQ-030 The cycle count from busy rising to done SHALL be exactly (2*DATA_W+2)*HALF_DIV.
REQ-031 rx_data SHALL change only at done; it holds between transfers.
REQ-032 start asserted in the done cycle SHALL be accepted (back-to-back transfers, one idle cycle).
REQ-033 In IDLE, sclk SHALL follow the cpol input, registered with one-cycle delay.

Reset
REQ-034 rst=0 SHALL immediately force: IDLE, sclk=0, mosi=0, ss_n all-ones, rx_data=0, busy=0, done=0, counters and shift registers=0.
REQ-035 Reset mid-transfer SHALL abort the transfer without a done pulse; the first transfer after release SHALL behave identically to one after power-up.

Verification (DATA_W=8, NUM_SLAVES=4, HALF_DIV=2)
REQ-036 Mode 0, MSB first, tx 0xA5, sel=2, miso looped from mosi -> ss_n=4'b1011 while busy; mosi bits 1,0,1,0,0,1,0,1; 16 sclk toggles; done 36 cycles after busy rises; rx_data=0xA5.
REQ-037 Mode 3, lsb_first=1, tx 0x3C, miso driven with the pattern for 0x96 LSB first -> sclk idles 1; mosi bits 0,0,1,1,1,1,0,0; rx_data=0x96.
REQ-038 start with tx 0x11, then start with 0x22 pulsed at cycle 10 of the transfer -> exactly one done; only 0x11 shifted out.
REQ-039 rst=0 after the 4th leading edge -> same cycle: ss_n=4'b1111, sclk=0, busy=0, rx_data=0; no done pulse.
REQ-040 NUM_SLAVES=3, sel=3 with start -> busy stays 0, ss_n=3'b111, no done.
REQ-041 start held high through done -> second transfer busy rises the cycle after done; two done pulses 37 cycles apart.
